// File: rtl/chunked_add_sub_v_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM state encoding
// and helpers that size the slice count and the slice counter.
package chunked_add_sub_v_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operation.
  function automatic int unsigned nchunk_f(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Slice counter width: clog2(n), never less than one bit.
  function automatic int unsigned cnt_w_f(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_ripple_adder_v.sv
// CHUNK-bit combinational ripple-carry adder built from full_adder_v cells.
//   a, b : CHUNK-bit addends      ci   : carry-in
//   s    : CHUNK-bit sum          co   : carry out of the MSB
//   cmsb : carry into the MSB (used for signed overflow)
module chunk_ripple_adder_v #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder_v u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/full_adder_v.sv
// One-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder_v (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_add_sub_v.sv
// Multi-cycle WIDTH-bit adder/subtractor processing one CHUNK-bit slice per
// clock with a registered carry between slices, behind valid/ready handshakes.
//   CLK, RST            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   A, B, C0, SUB       : operands, add carry-in, subtract select
//   out_valid/out_ready : result handshake
//   S, Cout, OVF, Z     : result, carry-out, signed overflow, zero flag
module chunked_add_sub_v
  import chunked_add_sub_v_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF,
  output logic             Z
);

  localparam int unsigned NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int unsigned CNT_W  = cnt_w_f(NCHUNK);
  localparam int unsigned OFF_W  = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, chunk_mask;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, last;
  logic [OFF_W-1:0] off;
  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_cmsb;

  // Ready in IDLE, or in DONE when the result is being taken this edge.
  assign in_ready = ~RST & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign last     = (cnt_q == LAST);

  // Current slice selection and accumulator merge.
  assign off        = OFF_W'(cnt_q) * OFF_W'(CHUNK);
  assign sl_a       = CHUNK'(a_q >> off);
  assign sl_b       = CHUNK'(b_q >> off);
  assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << off;
  assign acc_d      = (acc_q & ~chunk_mask) | (WIDTH'(sl_s) << off);

  chunk_ripple_adder_v #(.CHUNK(CHUNK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .ci   (carry_q),
    .s    (sl_s),
    .co   (sl_co),
    .cmsb (sl_cmsb)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, slice datapath and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      OVF       <= 1'b0;
      Z         <= 1'b0;
    end else begin
      out_valid <= (state_d == DONE);
      if (accept) begin
        a_q     <= A;
        b_q     <= B ^ {WIDTH{SUB}};
        carry_q <= SUB | C0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q   <= acc_d;
        carry_q <= sl_co;
        if (last) begin
          S    <= acc_d;
          Cout <= sl_co;
          OVF  <= sl_cmsb ^ sl_co;
          Z    <= (acc_d == '0);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_add_sub_v.sv
// Self-checking bench for chunked_add_sub_v: directed scenarios on a 32/8
// instance plus randomized sweeps over several WIDTH/CHUNK instances, all
// checked against a plain-arithmetic reference model.
module tb_chunked_add_sub_v;

  localparam int unsigned NDUT = 5;
  localparam int unsigned WS [NDUT] = '{32, 32, 32, 16, 8};
  localparam int unsigned CS [NDUT] = '{8, 32, 1, 4, 8};
  localparam int NOPS = 500;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, c0, sub;
  logic [31:0] a, b;
  int sel;

  logic [NDUT-1:0]       ir_v, ov_v, co_v, ovf_v, z_v;
  logic [NDUT-1:0][31:0] s_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = WS[g];
    localparam int unsigned C = CS[g];
    logic [W-1:0] s_w;
    chunked_add_sub_v #(.WIDTH(W), .CHUNK(C)) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .in_valid  (in_valid && (sel == g)),
      .in_ready  (ir_v[g]),
      .A         (a[W-1:0]),
      .B         (b[W-1:0]),
      .C0        (c0),
      .SUB       (sub),
      .out_valid (ov_v[g]),
      .out_ready (out_ready),
      .S         (s_w),
      .Cout      (co_v[g]),
      .OVF       (ovf_v[g]),
      .Z         (z_v[g])
    );
    assign s_v[g] = 32'(s_w);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit A + B + C0, or A - B, evaluated in wide arithmetic.
  task automatic golden(input int unsigned w, input logic [31:0] av, input logic [31:0] bv,
                        input logic c0v, input logic subv,
                        output logic [31:0] es, output logic ec, output logic eo, output logic ez);
    logic [63:0] m, aa, bb, full;
    m    = (64'd1 << w) - 64'd1;
    aa   = {32'd0, av} & m;
    bb   = subv ? (~{32'd0, bv} & m) : ({32'd0, bv} & m);
    full = aa + bb + {63'd0, (subv ? 1'b1 : c0v)};
    es   = full[31:0] & m[31:0];
    ec   = full[w];
    eo   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    ez   = (es == 32'd0);
  endtask

  // Issue one op on DUT g (must be able to accept with out_ready=orv), check
  // latency and result, then hold the result for 'stall' cycles.
  task automatic run_op(input int g, input logic [31:0] av, input logic [31:0] bv,
                        input logic c0v, input logic subv, input logic orv, input int stall);
    int unsigned nexp;
    int n;
    logic [31:0] es;
    logic ec, eo, ez;
    nexp = WS[g] / CS[g];
    golden(WS[g], av, bv, c0v, subv, es, ec, eo, ez);
    sel = g; a = av; b = bv; c0 = c0v; sub = subv; in_valid = 1'b1; out_ready = orv;
    #1;
    check("in_ready_pre", 64'(ir_v[g]), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("ov_after_accept", 64'(ov_v[g]), 64'd0);
    n = 0;
    while (!ov_v[g] && n < 64) begin
      a = $urandom; b = $urandom; c0 = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("latency", 64'(n), 64'(nexp));
    check("S", 64'(s_v[g]), 64'(es));
    check("Cout", 64'(co_v[g]), 64'(ec));
    check("OVF", 64'(ovf_v[g]), 64'(eo));
    check("Z", 64'(z_v[g]), 64'(ez));
    repeat (stall) begin
      @(posedge clk); #1;
      check("hold_ov", 64'(ov_v[g]), 64'd1);
      check("hold_S", 64'(s_v[g]), 64'(es));
    end
  endtask

  // Take the pending result without a new accept.
  task automatic release_res(input int g);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ov_after_release", 64'(ov_v[g]), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int pick;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c0 = 1'b0; sub = 1'b0;
    a = '0; b = '0; sel = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ir_v[0]), 64'd0);
    check("rst_ov", 64'(ov_v[0]), 64'd0);
    check("rst_S", 64'(s_v[0]), 64'd0);
    check("rst_flags", 64'({co_v[0], ovf_v[0], z_v[0]}), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(ir_v[0]), 64'd1);

    // Directed ops on the 32/8 instance.
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
    check("t1_S", 64'(s_v[0]), 64'h100);
    release_res(0);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0);
    check("t2_CZ", 64'({co_v[0], z_v[0]}), 64'd3);
    release_res(0);
    run_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
    check("t3_S", 64'(s_v[0]), 64'h8000_0000);
    check("t3_OVF", 64'(ovf_v[0]), 64'd1);
    release_res(0);

    // Backpressure in DONE, then same-edge handshake and accept.
    run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 0);
    repeat (5) begin
      a = $urandom; in_valid = ~in_valid;
      #1;
      check("bp_in_ready", 64'(ir_v[0]), 64'd0);
      @(posedge clk); #1;
      check("bp_ov", 64'(ov_v[0]), 64'd1);
      check("bp_S", 64'(s_v[0]), 64'h2345_6789);
    end
    in_valid = 1'b0;
    run_op(0, 32'd5, 32'd3, 1'b0, 1'b0, 1'b1, 0);
    check("t4_S", 64'(s_v[0]), 64'd8);
    release_res(0);

    // Reset during the second RUN cycle aborts the op.
    sel = 0; a = 32'hDEAD_BEEF; b = 32'h1; sub = 1'b0; c0 = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ov", 64'(ov_v[0]), 64'd0);
    check("abort_S", 64'(s_v[0]), 64'd0);
    check("abort_in_ready_rst", 64'(ir_v[0]), 64'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(ir_v[0]), 64'd1);
    repeat (8) begin
      @(posedge clk); #1;
      check("abort_no_result", 64'(ov_v[0]), 64'd0);
    end

    // Random sweeps over the other instances.
    for (int g = 1; g < int'(NDUT); g++) begin
      for (int i = 0; i < NOPS; i++) begin
        pick = $urandom_range(0, 7);
        ra = (pick == 0) ? 32'hFFFF_FFFF : (pick == 1) ? 32'd0 : $urandom;
        rb = (pick == 2) ? 32'hFFFF_FFFF : (pick == 3) ? 32'd0 : $urandom;
        if (i > 0 && $urandom_range(0, 1) == 1) begin
          run_op(g, ra, rb, 1'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 3));
        end else begin
          if (i > 0) release_res(g);
          run_op(g, ra, rb, 1'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 3));
        end
      end
      release_res(g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
